// File: rtl/alu_writeback_if.sv
// Handshake bundle between the ALU, the writeback stage and the register file.
// Carries the ALU result, the register file write port and the ALU flags.
interface alu_writeback_if #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] ALU_OUT;
  logic          ALU_SC_OUT;
  logic          ALU_ZERO;
  logic          ALU_BRANCH;
  logic [AW-1:0] IN_ADDR;
  logic          IN_WE;
  logic          IN_SET_SC;
  logic          CLR_SC;
  logic          WB_VALID;
  logic          WB_READY;
  logic [DW-1:0] WB_DATA;
  logic [AW-1:0] WB_ADDR;
  logic          WB_WE;
  logic          SC_FLAG;
  logic          ZERO_FLAG;
  logic          BR_FLAG;
  logic [CW-1:0] COUNT;

  modport master (
    output IN_VALID, ALU_OUT, ALU_SC_OUT,
    output ALU_ZERO, ALU_BRANCH, IN_ADDR,
    output IN_WE, IN_SET_SC, CLR_SC,
    output WB_READY,
    input  IN_READY, WB_VALID, WB_DATA,
    input  WB_ADDR, WB_WE, SC_FLAG,
    input  ZERO_FLAG, BR_FLAG, COUNT
  );

  modport slave (
    input  IN_VALID, ALU_OUT, ALU_SC_OUT,
    input  ALU_ZERO, ALU_BRANCH, IN_ADDR,
    input  IN_WE, IN_SET_SC, CLR_SC,
    input  WB_READY,
    output IN_READY, WB_VALID, WB_DATA,
    output WB_ADDR, WB_WE, SC_FLAG,
    output ZERO_FLAG, BR_FLAG, COUNT
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: in-order result FIFO plus carry/zero/branch flags.
// Optional same-cycle bypass when empty: define ALU_WB_BYPASS_EN.
module alu_writeback #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 2
) (
  input logic           Clk,
  input logic           Reset,
  alu_writeback_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] data_q [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic          we_q   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          sc_q;
  logic          zero_q;
  logic          br_q;

  logic not_empty;
  logic in_ready;
  logic push;
  logic bypass;
  logic enq;
  logic deq;

  assign not_empty = (count != '0);
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = bus.IN_VALID & in_ready;

`ifdef ALU_WB_BYPASS_EN
  assign bypass = ~not_empty & bus.IN_VALID & bus.WB_READY;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed result is consumed directly and never occupies a slot.
  assign enq = push & ~bypass;
  assign deq = not_empty & bus.WB_READY;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sc_q   <= 1'b0;
      zero_q <= 1'b0;
      br_q   <= 1'b0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + PW'(1);
      if (deq)
        rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push) begin
        zero_q <= bus.ALU_ZERO;
        br_q   <= bus.ALU_BRANCH;
      end
      if (bus.CLR_SC)
        sc_q <= 1'b0;
      else if (push && bus.IN_SET_SC)
        sc_q <= bus.ALU_SC_OUT;
    end
  end

  always_ff @(posedge Clk) begin
    if (enq && !Reset) begin
      data_q[wr_ptr] <= bus.ALU_OUT;
      addr_q[wr_ptr] <= bus.IN_ADDR;
      we_q[wr_ptr]   <= bus.IN_WE;
    end
  end

  always_comb begin
    bus.WB_DATA = '0;
    bus.WB_ADDR = '0;
    bus.WB_WE   = 1'b0;
    if (not_empty) begin
      bus.WB_DATA = data_q[rd_ptr];
      bus.WB_ADDR = addr_q[rd_ptr];
      bus.WB_WE   = we_q[rd_ptr];
    end else if (bypass) begin
      bus.WB_DATA = bus.ALU_OUT;
      bus.WB_ADDR = bus.IN_ADDR;
      bus.WB_WE   = bus.IN_WE;
    end
  end

  assign bus.WB_VALID  = not_empty | bypass;
  assign bus.IN_READY  = in_ready;
  assign bus.COUNT     = count;
  assign bus.SC_FLAG   = sc_q;
  assign bus.ZERO_FLAG = zero_q;
  assign bus.BR_FLAG   = br_q;
endmodule

// File: tb/tb_alu_writeback.sv
// Directed vector bench for alu_writeback (DW=8, AW=4, DEPTH=2).
// Build with +define+ALU_WB_BYPASS_EN to exercise the bypass path.
module tb_alu_writeback;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_writeback_if #(.DW(8), .AW(4), .DEPTH(2)) bus ();

  alu_writeback #(.DW(8), .AW(4), .DEPTH(2)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, iv;
    logic [7:0] dat;
    logic       sc, zr, br;
    logic [3:0] ad;
    logic       we, ss, cs, wr;
    logic       ev;
    logic [7:0] ed;
    logic [3:0] ea;
    logic       ew, er;
    logic [1:0] ec;
    logic       esc, ez, eb;
  } vec_t;

  vec_t v [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst            = 1'b0;
    bus.IN_VALID   = 1'b0;
    bus.ALU_OUT    = '0;
    bus.ALU_SC_OUT = 1'b0;
    bus.ALU_ZERO   = 1'b0;
    bus.ALU_BRANCH = 1'b0;
    bus.IN_ADDR    = '0;
    bus.IN_WE      = 1'b0;
    bus.IN_SET_SC  = 1'b0;
    bus.CLR_SC     = 1'b0;
    bus.WB_READY   = 1'b0;
  endtask

  task automatic drive(input vec_t t);
    rst            = t.rst;
    bus.IN_VALID   = t.iv;
    bus.ALU_OUT    = t.dat;
    bus.ALU_SC_OUT = t.sc;
    bus.ALU_ZERO   = t.zr;
    bus.ALU_BRANCH = t.br;
    bus.IN_ADDR    = t.ad;
    bus.IN_WE      = t.we;
    bus.IN_SET_SC  = t.ss;
    bus.CLR_SC     = t.cs;
    bus.WB_READY   = t.wr;
  endtask

  task automatic check_vec(input int i, input vec_t t);
    chk($sformatf("v%0d wb_valid", i), 32'(bus.WB_VALID), 32'(t.ev));
    chk($sformatf("v%0d wb_data", i), 32'(bus.WB_DATA), 32'(t.ed));
    chk($sformatf("v%0d wb_addr", i), 32'(bus.WB_ADDR), 32'(t.ea));
    chk($sformatf("v%0d wb_we", i), 32'(bus.WB_WE), 32'(t.ew));
    chk($sformatf("v%0d in_ready", i), 32'(bus.IN_READY), 32'(t.er));
    chk($sformatf("v%0d count", i), 32'(bus.COUNT), 32'(t.ec));
    chk($sformatf("v%0d sc_flag", i), 32'(bus.SC_FLAG), 32'(t.esc));
    chk($sformatf("v%0d zero_flag", i), 32'(bus.ZERO_FLAG), 32'(t.ez));
    chk($sformatf("v%0d br_flag", i), 32'(bus.BR_FLAG), 32'(t.eb));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle();

    //       rst iv dat   sc zr br ad  we ss cs wr   ev ed    ea  ew er ec sc z b
    v[0]  = '{1,1,8'hAA,1,1,1,4'd5,1,1,0,0, 0,8'h00,4'd0,0,1,2'd0,0,0,0};
    v[1]  = '{1,1,8'hAA,1,1,1,4'd5,1,1,0,0, 0,8'h00,4'd0,0,1,2'd0,0,0,0};
    v[2]  = '{0,1,8'h11,0,0,1,4'd1,1,0,0,0, 1,8'h11,4'd1,1,1,2'd1,0,0,1};
    v[3]  = '{0,1,8'h22,0,1,0,4'd2,0,0,0,0, 1,8'h11,4'd1,1,0,2'd2,0,1,0};
    v[4]  = '{0,1,8'h33,0,0,1,4'd3,1,0,0,0, 1,8'h11,4'd1,1,0,2'd2,0,1,0};
    v[5]  = '{0,1,8'h33,0,0,1,4'd3,1,0,0,1, 1,8'h22,4'd2,0,1,2'd1,0,1,0};
    v[6]  = '{0,1,8'h33,0,0,1,4'd3,1,0,0,1, 1,8'h33,4'd3,1,1,2'd1,0,0,1};
    v[7]  = '{0,0,8'h00,0,0,0,4'd0,0,0,0,1, 0,8'h00,4'd0,0,1,2'd0,0,0,1};
    v[8]  = '{0,0,8'h00,0,0,0,4'd0,0,0,0,1, 0,8'h00,4'd0,0,1,2'd0,0,0,1};
    v[9]  = '{0,1,8'h00,1,1,0,4'd4,1,1,0,0, 1,8'h00,4'd4,1,1,2'd1,1,1,0};
    v[10] = '{0,1,8'h01,0,0,0,4'd5,1,0,0,1, 1,8'h01,4'd5,1,1,2'd1,1,0,0};
    v[11] = '{0,1,8'h80,1,1,1,4'd6,1,1,1,0, 1,8'h01,4'd5,1,0,2'd2,0,1,1};
    v[12] = '{0,0,8'h00,0,0,0,4'd0,0,0,0,1, 1,8'h80,4'd6,1,1,2'd1,0,1,1};
    v[13] = '{0,1,8'h3C,1,0,0,4'd7,0,1,0,0, 1,8'h80,4'd6,1,0,2'd2,1,0,0};
    v[14] = '{1,1,8'h55,1,1,1,4'd8,1,1,0,1, 0,8'h00,4'd0,0,1,2'd0,0,0,0};
    v[15] = '{0,0,8'h00,0,0,0,4'd0,0,0,0,0, 0,8'h00,4'd0,0,1,2'd0,0,0,0};

    for (int i = 0; i < 16; i++) begin
      drive(v[i]);
      @(posedge clk);
      #1 idle();
      #1 check_vec(i, v[i]);
    end

    // IN_READY must stay low while full even with WB_READY high.
    bus.IN_VALID = 1'b1;
    bus.ALU_OUT  = 8'h44;
    @(posedge clk);
    @(posedge clk);
    #1 bus.WB_READY = 1'b1;
    #1 chk("full ready", 32'(bus.IN_READY), 32'd0);
    chk("full count", 32'(bus.COUNT), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1 idle();
    #1 chk("rst count", 32'(bus.COUNT), 32'd0);

`ifndef ALU_WB_BYPASS_EN
    bus.IN_VALID = 1'b1;
    bus.ALU_OUT  = 8'h5A;
    bus.IN_ADDR  = 4'd3;
    bus.IN_WE    = 1'b1;
    bus.WB_READY = 1'b1;
    @(posedge clk);
    #1 idle();
    bus.WB_READY = 1'b1;
    #1 chk("single valid", 32'(bus.WB_VALID), 32'd1);
    chk("single data", 32'(bus.WB_DATA), 32'h5A);
    chk("single addr", 32'(bus.WB_ADDR), 32'd3);
    chk("single we", 32'(bus.WB_WE), 32'd1);
    @(posedge clk);
    #1 idle();
    #1 chk("single drained", 32'(bus.WB_VALID), 32'd0);
    chk("single count", 32'(bus.COUNT), 32'd0);
`else
    bus.IN_VALID = 1'b1;
    bus.ALU_OUT  = 8'h7E;
    bus.IN_ADDR  = 4'd9;
    bus.IN_WE    = 1'b1;
    bus.ALU_ZERO = 1'b1;
    bus.WB_READY = 1'b1;
    #1 chk("byp valid", 32'(bus.WB_VALID), 32'd1);
    chk("byp data", 32'(bus.WB_DATA), 32'h7E);
    chk("byp addr", 32'(bus.WB_ADDR), 32'd9);
    chk("byp ready", 32'(bus.IN_READY), 32'd1);
    @(posedge clk);
    #1 idle();
    #1 chk("byp count", 32'(bus.COUNT), 32'd0);
    chk("byp after", 32'(bus.WB_VALID), 32'd0);
    chk("byp zero", 32'(bus.ZERO_FLAG), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream stage of the combinational ALU: captures each ALU result (OUT, SC_OUT, ZERO, branch) together with its destination register address.
- Buffers results in a small in-order FIFO and presents them to the register file write port with a valid/ready handshake.
- Holds the architectural carry flag, which feeds the ALU SC_IN, plus the zero and branch flags, so multi-byte add/shift chains work back to back.

Parameters:
DW, 8, data width of ALU result and register file write data
AW, 4, register file address width
DEPTH, 2, result FIFO entries (power of two, >= 2)

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
IN_VALID  input  1  ALU result valid this cycle
IN_READY  output  1  stage can accept a result
ALU_OUT  input  DW  ALU result
ALU_SC_OUT  input  1  ALU shift/carry out
ALU_ZERO  input  1  ALU zero flag
ALU_BRANCH  input  1  ALU branch indication
IN_ADDR  input  AW  destination register
IN_WE  input  1  result is to be written to the register file
IN_SET_SC  input  1  this op updates the carry flag
CLR_SC  input  1  synchronous clear of the carry flag
WB_VALID  output  1  head entry valid
WB_READY  input  1  register file accepts the head entry
WB_DATA  output  DW  head entry data
WB_ADDR  output  AW  head entry address
WB_WE  output  1  head entry write enable
SC_FLAG  output  1  carry flag, drives ALU SC_IN
ZERO_FLAG  output  1  zero flag of last accepted result
BR_FLAG  output  1  branch flag of last accepted result
COUNT  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (synchronous, active-high): COUNT=0, pointers=0, SC_FLAG=0, ZERO_FLAG=0, BR_FLAG=0, WB_VALID=0. Reset dominates every other input in the same cycle, including an in-flight push or pop.
- Push = IN_VALID & IN_READY. Pop = WB_VALID & WB_READY.
- IN_READY = (COUNT < DEPTH).
  - Registered-state function only; no combinational path from WB_READY.
  - When the FIFO is full, IN_READY=0 even in a cycle where a pop occurs.
- Every accepted result is enqueued, including IN_WE=0 entries, so ordering is preserved.
- Push stores {ALU_OUT, IN_ADDR, IN_WE}.
- Head-output presentation:
  - When COUNT>0: WB_VALID=1 and WB_DATA, WB_ADDR, WB_WE show the head entry.
  - When COUNT=0: WB_DATA=0, WB_ADDR=0, WB_WE=0.
- Latency: a result pushed at edge N is visible on WB_* after edge N, provided the FIFO was empty.
- Simultaneous push and pop (COUNT 1..DEPTH-1): COUNT is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Push while IN_VALID=0, or pop while empty: no state change.
- Flags update on push only, not on pop:
  - ZERO_FLAG <= ALU_ZERO
  - BR_FLAG <= ALU_BRANCH
  - SC_FLAG <= ALU_SC_OUT, only if IN_SET_SC=1
- SC_FLAG is therefore valid for the next ALU op in the cycle after the push.
- CLR_SC: SC_FLAG <= 0.
  - Priority: Reset > CLR_SC > push update.
  - CLR_SC does not block the push or the other flag updates.
- Carry flag is never modified by the FIFO draining.

Optional Feature:
ALU_WB_BYPASS_EN
- Defined: when COUNT=0, IN_VALID=1 and WB_READY=1, the input passes combinationally to WB_* in the same cycle. WB_VALID=1 that cycle, the entry is not enqueued, and COUNT stays 0. Flags still update on that edge. IN_READY is unchanged.
- Undefined: no bypass; minimum latency 1 cycle as above.

Test Plan:
- Reset then idle: hold Reset 2 cycles with IN_VALID=1 -> WB_VALID=0, COUNT=0, SC_FLAG=0, IN_READY=1 after release.
- Single result: ALU_OUT=0x5A, IN_ADDR=3, IN_WE=1, WB_READY=1 -> next cycle WB_DATA=0x5A, WB_ADDR=3, WB_WE=1, WB_VALID=1; cycle after, WB_VALID=0.
- Backpressure: WB_READY=0 and push 0x11, 0x22, 0x33 -> first two accepted, IN_READY=0 on the third, COUNT=2. Raise WB_READY -> outputs 0x11 then 0x22; 0x33 accepted once COUNT<2.
- Carry chain: push 0xFF+0x01 result 0x00 with SC_OUT=1, IN_SET_SC=1 -> SC_FLAG=1, ZERO_FLAG=1. Then push with IN_SET_SC=0, SC_OUT=0 -> SC_FLAG stays 1.
- Flag priority: CLR_SC=1 with a push carrying SC_OUT=1, IN_SET_SC=1 -> SC_FLAG=0, entry enqueued, ZERO_FLAG updated.
- Mid-operation reset: COUNT=2, assert Reset with a simultaneous push and pop -> next cycle COUNT=0, WB_VALID=0, all flags 0.
- (Bypass build) Empty FIFO, push 0x7E with WB_READY=1 -> WB_DATA=0x7E and WB_VALID=1 in the same cycle, COUNT remains 0.
